// File: rtl/game_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl_if
// Brief    : Button/collision inputs and session outputs of the game-flow controller
// Revision : 1.0
// ============================================================================
interface game_flow_ctrl_if #(
  parameter int COUNT_STEPS = 3
);
  localparam int CNT_W = $clog2(COUNT_STEPS + 1);

  logic             play;
  logic             pause;
  logic             collide;
  logic             start_game;
  logic             paused;
  logic             game_over;
  logic [CNT_W-1:0] countdown;
  logic             new_game;

  modport master (
    output play, pause, collide,
    input  start_game, paused, game_over, countdown, new_game
  );

  modport slave (
    input  play, pause, collide,
    output start_game, paused, game_over, countdown, new_game
  );
endinterface
`default_nettype wire

// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_ctrl
// Brief    : Session FSM (IDLE/COUNTDOWN/PLAY/PAUSED/OVER); GAME_PAUSE_EN enables pause
// Revision : 1.0
// ============================================================================
module game_flow_ctrl #(
  parameter int TICK_DIV    = 25_000_000,
  parameter int COUNT_STEPS = 3,
  parameter int HOLD_TICKS  = 4
) (
  input  wire logic       clk,
  input  wire logic       reset,
  game_flow_ctrl_if.slave bus
);
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W  = $clog2(COUNT_STEPS + 1);
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [DIV_W-1:0]  c_DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_COUNT_LOAD = CNT_W'(COUNT_STEPS);
  localparam logic [CNT_W-1:0]  c_COUNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] c_HOLD_DONE  = HOLD_W'(HOLD_TICKS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSED    = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [HOLD_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_count;
  logic              r_play_prev;
  logic              r_start;
  logic              r_paused;
  logic              r_over;
  logic              r_new;

  logic w_tick;
  logic w_play_edge;
  logic w_pause_edge;

  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_play_edge = bus.play & ~r_play_prev;

`ifdef GAME_PAUSE_EN
  // Prev flop resets high so a button held through reset yields no edge.
  logic r_pause_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pause_prev <= 1'b1;
    end else begin
      r_pause_prev <= bus.pause;
    end
  end

  assign w_pause_edge = bus.pause & ~r_pause_prev;
`else
  logic w_unused_pause;

  assign w_unused_pause = bus.pause;
  assign w_pause_edge   = 1'b0;
`endif

  // Outputs are registered alongside the state so they appear with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_hold      <= '0;
      r_count     <= '0;
      r_play_prev <= 1'b1;
      r_start     <= 1'b0;
      r_paused    <= 1'b0;
      r_over      <= 1'b0;
      r_new       <= 1'b0;
    end else begin
      r_play_prev <= bus.play;
      r_new       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_div <= '0;
          if (w_play_edge) begin
            r_state <= S_COUNTDOWN;
            r_count <= c_COUNT_LOAD;
            r_new   <= 1'b1;
          end
        end

        S_COUNTDOWN: begin
          r_div <= w_tick ? '0 : r_div + 1'b1;
          if (w_tick) begin
            if (r_count == c_COUNT_ONE) begin
              r_state <= S_PLAY;
              r_count <= '0;
              r_start <= 1'b1;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end

        S_PLAY: begin
          r_div <= '0;
          if (bus.collide) begin
            r_state <= S_OVER;
            r_start <= 1'b0;
            r_over  <= 1'b1;
            r_hold  <= '0;
          end else if (w_pause_edge) begin
            r_state  <= S_PAUSED;
            r_start  <= 1'b0;
            r_paused <= 1'b1;
          end
        end

`ifdef GAME_PAUSE_EN
        S_PAUSED: begin
          r_div <= '0;
          if (w_pause_edge || w_play_edge) begin
            r_state  <= S_PLAY;
            r_paused <= 1'b0;
            r_start  <= 1'b1;
          end
        end
`endif

        S_OVER: begin
          // The hold must already be complete before the edge arrives.
          if ((r_hold == c_HOLD_DONE) && w_play_edge) begin
            r_state <= S_COUNTDOWN;
            r_over  <= 1'b0;
            r_count <= c_COUNT_LOAD;
            r_new   <= 1'b1;
            r_hold  <= '0;
            r_div   <= '0;
          end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick && (r_hold != c_HOLD_DONE)) begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_div    <= '0;
          r_hold   <= '0;
          r_count  <= '0;
          r_start  <= 1'b0;
          r_paused <= 1'b0;
          r_over   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_game = r_start;
  assign bus.paused     = r_paused;
  assign bus.game_over  = r_over;
  assign bus.countdown  = r_count;
  assign bus.new_game   = r_new;

endmodule
`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_flow_ctrl
// Brief    : Scoreboard bench for game_flow_ctrl (TICK_DIV=4, COUNT_STEPS=3, HOLD_TICKS=2)
// Revision : 1.0
// ============================================================================
module tb_game_flow_ctrl;
  logic clk;
  logic reset;
  int   cyc;
  int   n_pass;
  int   n_total;

  typedef struct {
    int         cyc;
    string      tag;
    logic [5:0] exp;
  } item_t;

  item_t sb[$];

  game_flow_ctrl_if #(.COUNT_STEPS(3)) bus ();

  game_flow_ctrl #(
    .TICK_DIV   (4),
    .COUNT_STEPS(3),
    .HOLD_TICKS (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Vector order: {start_game, paused, game_over, countdown[1:0], new_game}
  function automatic logic [5:0] v(bit s, bit p, bit o, int cd, bit n);
    logic [1:0] c;
    c = cd[1:0];
    return {s, p, o, c, n};
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t it;
      it = sb.pop_front();
      if (it.cyc < cyc) begin
        check({it.tag, "_missed"}, 32'(cyc), 32'(it.cyc));
      end else begin
        check(it.tag, 32'({bus.start_game, bus.paused, bus.game_over,
                           bus.countdown, bus.new_game}), 32'(it.exp));
      end
    end
  end

  task automatic step(input bit r, input bit pl, input bit pa, input bit co,
                      input logic [5:0] exp, input string tag);
    item_t it;
    reset       = r;
    bus.play    = pl;
    bus.pause   = pa;
    bus.collide = co;
    it.cyc = cyc + 1;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
    @(posedge clk);
    #2;
  endtask

  task automatic countdown_to_play(input string tag);
    for (int i = 1; i < 12; i++) begin
      step(0, 0, 0, 0, v(0, 0, 0, 3 - i / 4, 0), tag);
    end
    step(0, 0, 0, 0, v(1, 0, 0, 0, 0), {tag, "_start"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] c_IDLE, c_PLAY, c_OVER, c_PAUSE;
    c_IDLE  = v(0, 0, 0, 0, 0);
    c_PLAY  = v(1, 0, 0, 0, 0);
    c_OVER  = v(0, 0, 1, 0, 0);
    c_PAUSE = v(0, 1, 0, 0, 0);
    cyc = 0; n_pass = 0; n_total = 0;
    reset = 1'b1; bus.play = 1'b1; bus.pause = 1'b1; bus.collide = 1'b0;
    @(posedge clk);
    #2;

    // Buttons held through reset must not create edges.
    step(1, 1, 1, 0, c_IDLE, "reset");
    step(1, 1, 1, 0, c_IDLE, "reset2");
    step(0, 1, 1, 0, c_IDLE, "held_play");
    step(0, 1, 1, 0, c_IDLE, "held_play2");
    step(0, 0, 0, 0, c_IDLE, "release");
    step(0, 1, 0, 0, v(0, 0, 0, 3, 1), "press_load");

    // Countdown with button noise and collide that must be ignored.
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "ng_low");
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "cd3_a");
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "cd3_b");
    step(0, 0, 0, 0, v(0, 0, 0, 2, 0), "cd2_a");
    step(0, 1, 1, 0, v(0, 0, 0, 2, 0), "cd_btn_ign");
    step(0, 0, 0, 1, v(0, 0, 0, 2, 0), "cd_col_ign");
    step(0, 0, 0, 0, v(0, 0, 0, 2, 0), "cd2_d");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, v(0, 0, 0, 1, 0), "cd1");
    step(0, 0, 0, 0, c_PLAY, "play_start");

    // PLAY ignores play edges; collide enters OVER next cycle.
    step(0, 1, 0, 0, c_PLAY, "play_ign");
    step(0, 0, 0, 0, c_PLAY, "play_ign2");
    step(0, 0, 0, 1, c_OVER, "collide");
    for (int j = 1; j <= 7; j++) begin
      step(0, (j == 2), 0, (j < 3), c_OVER, "over_hold");
    end
    step(0, 1, 0, 0, c_OVER, "over_same_cycle");
    step(0, 0, 0, 0, c_OVER, "over_done");
    step(0, 1, 0, 0, v(0, 0, 0, 3, 1), "restart_load");

    // Reset while countdown shows 2.
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "rs_cd3a");
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "rs_cd3b");
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "rs_cd3c");
    step(0, 0, 0, 0, v(0, 0, 0, 2, 0), "rs_cd2");
    step(1, 0, 0, 0, c_IDLE, "mid_reset");
    step(0, 0, 0, 0, c_IDLE, "post_reset");
    step(0, 0, 0, 0, c_IDLE, "post_reset2");

    step(0, 1, 0, 0, v(0, 0, 0, 3, 1), "press2");
    step(0, 0, 0, 0, v(0, 0, 0, 3, 0), "cd_b");
    for (int i = 2; i < 12; i++) begin
      step(0, 0, 0, 0, v(0, 0, 0, 3 - i / 4, 0), "cd_b");
    end
    step(0, 0, 0, 0, c_PLAY, "play_b");

`ifdef GAME_PAUSE_EN
    step(0, 0, 1, 0, c_PAUSE, "pause_in");
    step(0, 0, 0, 0, c_PAUSE, "pause_hold");
    step(0, 0, 0, 1, c_PAUSE, "pause_col_ign");
    step(0, 0, 0, 0, c_PAUSE, "pause_hold2");
    step(0, 0, 1, 0, c_PLAY, "pause_out");
    step(0, 0, 0, 0, c_PLAY, "resumed");
    step(0, 0, 1, 0, c_PAUSE, "pause_in2");
    step(0, 0, 0, 0, c_PAUSE, "pause_hold3");
    step(0, 1, 0, 0, c_PLAY, "play_resume");
    step(0, 0, 0, 0, c_PLAY, "resumed2");
`else
    step(0, 0, 1, 0, c_PLAY, "nopause1");
    step(0, 0, 0, 0, c_PLAY, "nopause2");
    step(0, 0, 1, 0, c_PLAY, "nopause3");
    step(0, 0, 0, 0, c_PLAY, "nopause4");
`endif
    step(0, 0, 1, 1, c_OVER, "col_pause_same");
    step(0, 0, 0, 0, c_OVER, "over_stay");

    @(negedge clk);
    @(negedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
